// File: rtl/mac_frame_accumulator_pkg.sv
// Shared types, default widths and overflow helper for the MAC frame
// accumulator family.
package mac_frame_accumulator_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam int DEF_PROD_W = 8;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_LEN    = 8;

  // Classifies a sum that was computed one bit wider than the accumulator.
  // ext_msb is the extra top bit, res_msb the accumulator's sign bit; they
  // differ exactly when the result does not fit. Width independent, so it
  // serves any accumulator width.
  // Return value: {positive overflow, negative overflow}.
  function automatic logic [1:0] add_ovf(input logic ext_msb, input logic res_msb);
    return {~ext_msb & res_msb, ext_msb & ~res_msb};
  endfunction

endpackage

// File: rtl/mac_frame_accumulator_sat_add.sv
// Combinational signed add with optional clamp and overflow flag.
module mac_frame_accumulator_sat_add
  import mac_frame_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int SAT   = 1
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    flag_o
);

  logic [ACC_W:0] wide;
  logic [1:0]     ovf;

  assign wide = {a_i[ACC_W-1], a_i} + {b_i[ACC_W-1], b_i};
  assign ovf  = add_ovf(wide[ACC_W], wide[ACC_W-1]);

  // Wrap by default; in saturating mode replace an overflowed result with the limit.
  always_comb begin
    sum_o  = wide[ACC_W-1:0];
    flag_o = |ovf;
    if (SAT != 0) begin
      if (ovf[1]) begin
        sum_o = {1'b0, {(ACC_W-1){1'b1}}};
      end else if (ovf[0]) begin
        sum_o = {1'b1, {(ACC_W-1){1'b0}}};
      end
    end
  end

endmodule

// File: rtl/mac_frame_accumulator.sv
// Accumulates signed products into per-frame dot-product results and
// presents each result through a valid/ready output register.
module mac_frame_accumulator
  import mac_frame_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN    = DEF_LEN,
  parameter int SAT    = 1,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_cnt,
  output logic                     out_sat
);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     sat_q;
  logic signed [ACC_W-1:0]  out_acc_q;
  logic [CNT_W-1:0]         out_cnt_q;
  logic                     out_sat_q;

  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic                     sum_flag;
  logic [CNT_W-1:0]         cnt_inc;
  logic                     accept, frame_end, deliver;

  // Acceptance is decoded from the registered state so in_ready never
  // depends combinationally on out_ready.
  assign prod_ext  = ACC_W'(in_prod);
  assign cnt_inc   = cnt_q + 1'b1;
  assign accept    = in_valid && (state_q == ACC);
  assign frame_end = accept && (in_last || (cnt_inc == CNT_W'(LEN)));
  assign deliver   = (state_q == DONE) && out_ready;

  mac_frame_accumulator_sat_add #(
    .ACC_W (ACC_W),
    .SAT   (SAT)
  ) u_sat_add (
    .a_i    (acc_q),
    .b_i    (prod_ext),
    .sum_o  (sum),
    .flag_o (sum_flag)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (frame_end) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // Running sum, term count and sticky flag; result captured on the frame's final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_acc_q <= '0;
      out_cnt_q <= '0;
      out_sat_q <= 1'b0;
    end else if (deliver) begin
      acc_q <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      acc_q <= sum;
      cnt_q <= cnt_inc;
      sat_q <= sat_q | sum_flag;
      if (frame_end) begin
        out_acc_q <= sum;
        out_cnt_q <= cnt_inc;
        out_sat_q <= sat_q | sum_flag;
      end
    end
  end

  assign out_acc = out_acc_q;
  assign out_cnt = out_cnt_q;
  assign out_sat = out_sat_q;

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Bench for mac_frame_accumulator: four configurations share one stimulus
// stream and are compared every cycle against a behavioural frame model.
module tb_mac_frame_accumulator;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic signed [7:0] in_prod;

  always #5 clk = ~clk;

  // Configurations: 0 default, 1 ACC_W=10 saturating, 2 ACC_W=10 wrapping, 3 LEN=1.
  int cfg_w[4]   = '{16, 10, 10, 16};
  int cfg_sat[4] = '{1, 1, 0, 1};
  int cfg_len[4] = '{8, 8, 8, 1};

  logic [3:0] rdy, vld, osat;
  logic signed [15:0] a0, a3;
  logic signed [9:0]  a1, a2;
  logic [3:0] c0, c1, c2;
  logic       c3;
  longint acc_o[4];
  int     cnt_o[4];

  mac_frame_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(8), .SAT(1)) d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_acc(a0),
    .out_cnt(c0), .out_sat(osat[0]));
  mac_frame_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(8), .SAT(1)) d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_acc(a1),
    .out_cnt(c1), .out_sat(osat[1]));
  mac_frame_accumulator #(.PROD_W(8), .ACC_W(10), .LEN(8), .SAT(0)) d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_acc(a2),
    .out_cnt(c2), .out_sat(osat[2]));
  mac_frame_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1), .SAT(1)) d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[3]), .in_prod(in_prod),
    .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_acc(a3),
    .out_cnt(c3), .out_sat(osat[3]));

  always_comb begin
    acc_o[0] = a0; acc_o[1] = a1; acc_o[2] = a2; acc_o[3] = a3;
    cnt_o[0] = int'(c0); cnt_o[1] = int'(c1); cnt_o[2] = int'(c2); cnt_o[3] = int'(c3);
  end

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int k, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", nm, k, got, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a list of accepted products summed with
  // clamp or wrap at the configured width; a result is pending until taken.
  longint m_acc[4], m_eacc[4];
  int     m_cnt[4], m_ecnt[4];
  bit     m_flag[4], m_esat[4], m_pend[4], m_fresh[4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        m_pend[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_flag[k] = 0;
        m_eacc[k] = 0; m_ecnt[k] = 0; m_esat[k] = 0; m_fresh[k] = 1;
      end else if (m_pend[k]) begin
        if (out_ready) begin
          m_pend[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_flag[k] = 0;
        end
      end else if (in_valid) begin
        longint s, hi, lo, span;
        span = longint'(1) << cfg_w[k];
        hi = (span / 2) - 1;
        lo = -(span / 2);
        s = m_acc[k] + longint'(in_prod);
        if (s > hi) begin
          m_flag[k] = 1;
          s = (cfg_sat[k] != 0) ? hi : s - span;
        end else if (s < lo) begin
          m_flag[k] = 1;
          s = (cfg_sat[k] != 0) ? lo : s + span;
        end
        m_acc[k] = s;
        m_cnt[k]++;
        if (in_last || m_cnt[k] == cfg_len[k]) begin
          m_pend[k] = 1; m_fresh[k] = 0;
          m_eacc[k] = m_acc[k]; m_ecnt[k] = m_cnt[k]; m_esat[k] = m_flag[k];
        end
      end
    end
  end

  // Per-cycle comparison of every configuration against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        chk("in_ready", k, longint'(rdy[k]), longint'(!m_pend[k]));
        chk("out_valid", k, longint'(vld[k]), longint'(m_pend[k]));
        if (m_pend[k]) begin
          chk("out_acc", k, acc_o[k], m_eacc[k]);
          chk("out_cnt", k, longint'(cnt_o[k]), longint'(m_ecnt[k]));
          chk("out_sat", k, longint'(osat[k]), longint'(m_esat[k]));
        end else if (m_fresh[k]) begin
          chk("out_acc_rst", k, acc_o[k], 0);
          chk("out_cnt_rst", k, longint'(cnt_o[k]), 0);
          chk("out_sat_rst", k, longint'(osat[k]), 0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int bubbles;

  // One beat, offered once the default configuration can take it.
  task automatic beat(input logic signed [7:0] p, input logic l);
    int n;
    n = 0;
    while (!rdy[0] && n < 20) begin
      in_valid = 1'b0;
      cyc();
      n++;
      bubbles++;
    end
    if (n >= 20) chk("beat_timeout", 0, n, 0);
    in_valid = 1'b1; in_prod = p; in_last = l;
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Hand-computed expectation checked against both DUT and model.
  task automatic pin(input string nm, input int k, input longint dut_v, input longint mod_v,
                     input longint exp);
    chk({nm, "_dut"}, k, dut_v, exp);
    chk({nm, "_model"}, k, mod_v, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
    cyc();
    chk_en = 1'b1;
    cyc();
    pin("rst_ready", 0, longint'(rdy[0]), 1, 1);
    pin("rst_acc", 0, acc_o[0], m_eacc[0], 0);
    rst = 1'b0;

    // Eight +64 beats: plain sum, clamp and wrap at 10 bits.
    for (int i = 0; i < 8; i++) beat(8'sh40, 1'b0);
    pin("sum_acc", 0, acc_o[0], m_eacc[0], 512);
    pin("sum_cnt", 0, longint'(cnt_o[0]), longint'(m_ecnt[0]), 8);
    pin("sum_sat", 0, longint'(osat[0]), longint'(m_esat[0]), 0);
    pin("clamp_acc", 1, acc_o[1], m_eacc[1], 511);
    pin("clamp_sat", 1, longint'(osat[1]), longint'(m_esat[1]), 1);
    pin("wrap_acc", 2, acc_o[2], m_eacc[2], -512);
    pin("wrap_sat", 2, longint'(osat[2]), longint'(m_esat[2]), 1);
    pin("len1_acc", 3, acc_o[3], m_eacc[3], 64);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // Mixed signs, early end, then held for five cycles.
    beat(8'sh40, 1'b0); beat(-8'sd56, 1'b0); beat(8'sd49, 1'b1);
    pin("mixed_acc", 0, acc_o[0], m_eacc[0], 57);
    pin("mixed_cnt", 0, longint'(cnt_o[0]), longint'(m_ecnt[0]), 3);
    for (int i = 0; i < 5; i++) cyc();
    pin("hold_acc", 0, acc_o[0], m_eacc[0], 57);
    pin("hold_ready", 0, longint'(rdy[0]), 0, 0);
    out_ready = 1'b1; cyc(); out_ready = 1'b0;

    // Eight -56 beats stay inside 10 bits.
    for (int i = 0; i < 8; i++) beat(-8'sd56, 1'b0);
    pin("neg_acc", 1, acc_o[1], m_eacc[1], -448);
    pin("neg_sat", 1, longint'(osat[1]), longint'(m_esat[1]), 0);

    // Back-to-back frames with the consumer always ready.
    out_ready = 1'b1; cyc();
    for (int i = 0; i < 8; i++) beat(8'sd5, 1'b0);
    bubbles = 0;
    for (int i = 0; i < 8; i++) beat(-8'sd1, 1'b0);
    pin("b2b_acc", 0, acc_o[0], m_eacc[0], -8);
    chk("b2b_bubbles", 0, bubbles, 1);
    cyc();

    // Reset in the middle of a frame, then a clean frame of +1.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'sd3, 1'b0);
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 8; i++) beat(8'sd1, 1'b0);
    pin("rst_mid_acc", 0, acc_o[0], m_eacc[0], 8);
    // Reset while a result waits: it must disappear.
    rst = 1'b1; cyc(); rst = 1'b0;
    pin("rst_drop_vld", 0, longint'(vld[0]), longint'(m_pend[0]), 0);
    out_ready = 1'b1; cyc(); cyc(); out_ready = 1'b0;
    pin("rst_never_vld", 0, longint'(vld[0]), longint'(m_pend[0]), 0);

    // Single-term frames: most negative product without in_last.
    beat(8'sh80, 1'b0);
    pin("len1_neg_acc", 3, acc_o[3], m_eacc[3], -128);
    pin("len1_neg_cnt", 3, longint'(cnt_o[3]), longint'(m_ecnt[3]), 1);
    out_ready = 1'b1; cyc();

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_prod   = 8'($urandom);
      in_last   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
